ifid_hazard_ctrl: RTL and testbench
===================================

# ifid_hazard_ctrl

Pipeline hazard controller that sequences the IF/ID register and PC update in the modified MIPS core. It detects three conditions and drives the PC and IF/ID write-enable, flush and bubble controls:
- load-use hazards against the EX stage;
- control redirects (taken branch from EX, jump decoded in ID);
- structural hazards on the multi-cycle FP unit (FR/FI formats).

It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- FP_LAT, 4, cycles the FP unit is occupied per issued FP op; legal range 1..15
- CNT_W, 16, width of stall counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs  in  5  rs/fmt field of instruction in IF/ID
- id_rt  in  5  rt/ft field of instruction in IF/ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_fp  in  1  ID instruction is an FP arithmetic op (FR/FI)
- id_is_jump  in  1  ID instruction is J-format jump
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination register of EX load
- ex_branch_taken  in  1  branch in EX resolved taken
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID clears to NOP on next edge (overrides ifid_we)
- idex_bubble  out  1  ID/EX loads a NOP instead of ID contents
- fp_busy  out  1  FP unit occupied
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- States: RUN, FP_BUSY. Occupancy counter occ (4 bits).
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- fp_hold = id_is_fp && state==FP_BUSY.
- Priority, evaluated each cycle:
  1. ex_branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1.
  2. id_is_jump: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=0.
  3. load_use or fp_hold (stall): pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1.
  4. Otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- FP issue occurs when id_is_fp, state==RUN, and neither load_use nor a redirect is active.
  - On issue with FP_LAT>1: next state FP_BUSY, occ=FP_LAT-1.
  - On issue with FP_LAT==1: stay in RUN.
- FP_BUSY: occ decrements each cycle; when occ==1 the next state is RUN. Non-FP instructions flow freely. A taken branch does not cancel occupancy.
- stall_cnt increments by 1 in every cycle where rule 3 is active, saturating at all-ones. Rule 3 firing on both load_use and fp_hold in the same cycle still adds only 1.
- Reset (rst high, any state): next state RUN, occ=0, stall_cnt=0. While rst is high, the outputs are forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, fp_busy=0. A reset during FP_BUSY discards the occupancy.

## Timing
- Control outputs are combinational from registered state and the current inputs, so the response comes in the same cycle with zero latency. fp_busy and stall_cnt are registered.
- Load-use stall lasts exactly 1 cycle: the bubble removes the load from EX on the next cycle.
- An FP op issued at edge N gives fp_busy=1 for the cycles after edges N..N+FP_LAT-2. A waiting FP op therefore issues FP_LAT cycles after its predecessor.
- A branch in the same cycle as load_use or fp_hold wins; no stall is counted.

## Structure
- Shared package mips_ctrl_pkg holds:
  - state enum {RUN, FP_BUSY};
  - REG_ZERO = 5'd0;
  - the NOP encoding used by the flush/bubble consumers.
- One natural sub-module: fp_occupancy_ctr, containing the occ load/decrement logic and the fp_busy register, parameterised by FP_LAT.
- Priority mux and load-use compare live in the top module.

## Test plan
- Reset: hold rst for 2 cycles → pc_we=0, ifid_flush=1, idex_bubble=1; after release, fp_busy=0 and stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rt=2, id_rs=2 → pc_we=0, ifid_we=0, idex_bubble=1 for 1 cycle, stall_cnt=1. Repeat with ex_rt=0 → no stall.
- FP back-to-back with FP_LAT=4: two FP ops in consecutive IDs → first issues; fp_busy high 3 cycles; second op stalled 3 cycles; stall_cnt=3; second op issues on the 4th cycle.
- Branch vs stall: ex_branch_taken=1 together with load_use=1 → ifid_flush=1, idex_bubble=1, pc_we=1; stall_cnt unchanged.
- Jump: id_is_jump=1 → ifid_flush=1, idex_bubble=0, pc_we=1.
- Reset mid-FP_BUSY with occ=2: assert rst → next cycle state RUN, fp_busy=0; a following FP op issues without stall.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
// Holds the FP occupancy state encoding and the IF/ID control bundle.
package mips_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    FP_BUSY = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;

  // sll $0,$0,0 -- what a flushed IF/ID or a bubbled ID/EX holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_BRANCH   = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_JUMP     = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};
  localparam ctrl_t CTRL_STALL    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam ctrl_t CTRL_FLOW     = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/fp_occupancy_ctr.sv
// Tracks how long the multi-cycle FP unit stays occupied after an issue.
// Owns the RUN/FP_BUSY state, the occupancy down-counter and the fp_busy flop.
module fp_occupancy_ctr
  import mips_ctrl_pkg::*;
#(
  parameter int FP_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy_state,
  output logic fp_busy
);

  localparam logic [3:0] OCC_LOAD = 4'(FP_LAT - 1);

  state_e     state, state_next;
  logic [3:0] occ, occ_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      occ     <= 4'd0;
      fp_busy <= 1'b0;
    end else begin
      state   <= state_next;
      occ     <= occ_next;
      fp_busy <= (state_next == FP_BUSY);
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    occ_next   = occ;
    case (state)
      RUN: begin
        // A single-cycle FP unit never blocks, so it stays in RUN.
        if (issue && (FP_LAT > 1)) begin
          state_next = FP_BUSY;
          occ_next   = OCC_LOAD;
        end
      end
      FP_BUSY: begin
        if (occ == 4'd1) begin
          state_next = RUN;
          occ_next   = 4'd0;
        end else begin
          occ_next   = occ - 4'd1;
        end
      end
      default: begin
        state_next = RUN;
        occ_next   = 4'd0;
      end
    endcase
  end

  assign busy_state = (state == FP_BUSY);

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller: load-use, branch/jump redirect and FP structural
// hazards drive PC / IF/ID / ID/EX controls; also counts stall cycles.
module ifid_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int FP_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_fp,
  input  logic             id_is_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             fp_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic  load_use;
  logic  fp_hold;
  logic  redirect;
  logic  stall;
  logic  fp_issue;
  logic  busy_state;
  logic  fp_busy_q;
  ctrl_t ctrl;

  always_comb begin
    load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    fp_hold  = id_is_fp && busy_state;
    redirect = ex_branch_taken || id_is_jump;
    // A redirect squashes the ID instruction, so its hazards are moot.
    stall    = !redirect && (load_use || fp_hold);
    fp_issue = id_is_fp && !busy_state && !load_use && !redirect && !rst;

    ctrl = CTRL_FLOW;
    if (rst)                  ctrl = CTRL_RESET;
    else if (ex_branch_taken) ctrl = CTRL_BRANCH;
    else if (id_is_jump)      ctrl = CTRL_JUMP;
    else if (stall)           ctrl = CTRL_STALL;
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;

  fp_occupancy_ctr #(
    .FP_LAT (FP_LAT)
  ) u_fp_occ (
    .clk        (clk),
    .rst        (rst),
    .issue      (fp_issue),
    .busy_state (busy_state),
    .fp_busy    (fp_busy_q)
  );

  // The flop only clears at the reset edge; mask it while rst is still high.
  assign fp_busy = fp_busy_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !rst && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed self-checking bench for ifid_hazard_ctrl with FP_LAT=4, CNT_W=16.
module tb_ifid_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_is_fp, id_is_jump, ex_mem_read, ex_branch_taken;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, fp_busy;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ifid_hazard_ctrl #(
    .FP_LAT (4),
    .CNT_W  (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_is_fp        (id_is_fp),
    .id_is_jump      (id_is_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fp_busy         (fp_busy),
    .stall_cnt       (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control bundle packed as {pc_we, ifid_we, ifid_flush, idex_bubble}.
  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_we, ifid_we, ifid_flush, idex_bubble}, {28'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_is_fp = 1'b0;
    id_is_jump = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    check_ctrl("reset_ctrl", 4'b0011);
    check("reset_fp_busy", {31'd0, fp_busy}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_ctrl("post_reset_flow", 4'b1100);
    check("post_reset_fp_busy", {31'd0, fp_busy}, 32'd0);
    check("post_reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Load-use on rs
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    #1;
    check_ctrl("load_use_rs", 4'b0001);
    tick();
    ex_mem_read = 1'b0;
    #1;
    check_ctrl("load_use_cleared", 4'b1100);
    check("load_use_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load-use on rt only matters when rt is a source
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd0; id_rt = 5'd5; id_uses_rt = 1'b1;
    #1;
    check_ctrl("load_use_rt", 4'b0001);
    id_uses_rt = 1'b0;
    #1;
    check_ctrl("rt_not_source", 4'b1100);

    // Loads into $0 never stall
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    check_ctrl("ex_rt_zero", 4'b1100);
    tick();
    check("ex_rt_zero_cnt", {16'd0, stall_cnt}, 32'd1);
    clear_inputs();

    // Back-to-back FP ops, FP_LAT=4
    id_is_fp = 1'b1;
    #1;
    check_ctrl("fp_first_issue", 4'b1100);
    tick();
    check("fp_busy_1", {31'd0, fp_busy}, 32'd1);
    check_ctrl("fp_hold_1", 4'b0001);
    tick();
    check("fp_busy_2", {31'd0, fp_busy}, 32'd1);
    check_ctrl("fp_hold_2", 4'b0001);
    tick();
    check("fp_busy_3", {31'd0, fp_busy}, 32'd1);
    check_ctrl("fp_hold_3", 4'b0001);
    tick();
    check("fp_busy_done", {31'd0, fp_busy}, 32'd0);
    check_ctrl("fp_second_issue", 4'b1100);
    check("fp_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    tick();
    check("fp_second_busy", {31'd0, fp_busy}, 32'd1);

    // Branch wins over fp_hold and does not cancel occupancy
    ex_branch_taken = 1'b1;
    #1;
    check_ctrl("branch_over_fp_hold", 4'b1111);
    tick();
    check("branch_cnt_unchanged", {16'd0, stall_cnt}, 32'd4);
    check("branch_keeps_busy", {31'd0, fp_busy}, 32'd1);

    // Branch wins over load-use
    id_is_fp = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    #1;
    check_ctrl("branch_over_load_use", 4'b1111);

    // Jump wins over load-use
    ex_branch_taken = 1'b0; id_is_jump = 1'b1;
    #1;
    check_ctrl("jump", 4'b1110);
    clear_inputs();

    // Non-FP instruction flows while the FP unit is busy
    #1;
    check_ctrl("non_fp_during_busy", 4'b1100);

    // Reset mid FP_BUSY (occ=2) discards the occupancy
    rst = 1'b1;
    #1;
    check_ctrl("reset_mid_busy_ctrl", 4'b0011);
    check("reset_mid_busy_fp_busy", {31'd0, fp_busy}, 32'd0);
    tick();
    rst = 1'b0;
    id_is_fp = 1'b1;
    #1;
    check("after_reset_fp_busy", {31'd0, fp_busy}, 32'd0);
    check("after_reset_cnt", {16'd0, stall_cnt}, 32'd0);
    check_ctrl("after_reset_fp_issue", 4'b1100);
    tick();
    check("after_reset_fp_issued", {31'd0, fp_busy}, 32'd1);
    check_ctrl("after_reset_fp_hold", 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
